// File: rtl/bcd_updown_counter_7seg_if.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_7seg_if
// Bundles the control, load and display signals of the BCD up/down counter.
//   EN, UP, LOAD, LOAD_VAL      : count enable, direction, sync load, value
//   LED_type_ctl, BLANK_ctl     : segment polarity, leading-zero blanking
//   COUNT, LED, WRAP, LOAD_ERR  : counter value, segments, event pulses
// master = the side that drives the controls (board logic / testbench)
// slave  = the counter itself
// ---------------------------------------------------------------------------
interface bcd_updown_counter_7seg_if #(
    parameter int DIGITS = 4
);
    logic                  EN;
    logic                  UP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic                  LED_type_ctl;
    logic                  BLANK_ctl;
    logic [4*DIGITS-1:0]   COUNT;
    logic [7*DIGITS-1:0]   LED;
    logic                  WRAP;
    logic                  LOAD_ERR;

    modport master (
        output EN, UP, LOAD, LOAD_VAL, LED_type_ctl, BLANK_ctl,
        input  COUNT, LED, WRAP, LOAD_ERR
    );

    modport slave (
        input  EN, UP, LOAD, LOAD_VAL, LED_type_ctl, BLANK_ctl,
        output COUNT, LED, WRAP, LOAD_ERR
    );
endinterface

// File: rtl/bcd_updown_counter_7seg.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_7seg
// N-digit BCD up/down counter with synchronous load, wrap flag, leading-zero
// blanking and selectable segment polarity.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : slave side of bcd_updown_counter_7seg_if (controls in, COUNT /
//          LED / WRAP / LOAD_ERR out). COUNT, WRAP and LOAD_ERR are
//          registered; LED is decoded combinationally from COUNT.
// ---------------------------------------------------------------------------
module bcd_updown_counter_7seg #(
    parameter int DIGITS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    bcd_updown_counter_7seg_if.slave  bus
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;
    logic                carry_s;
    logic [3:0]          step_dig_s;
    logic [3:0]          disp_dig_s;
    logic                upper_zero_s;
    logic [6:0]          seg_s;
    logic [7*DIGITS-1:0] led_s;

    // Active-high abcdefg pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] dig);
        logic [6:0] seg;
        case (dig)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // Next-state: load (with non-BCD scrub) beats ripple step beats hold.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        carry_s    = 1'b0;
        step_dig_s = 4'd0;
        if (bus.LOAD) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bus.LOAD_VAL[4*i +: 4] > 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                    load_err_d        = 1'b1;
                end else begin
                    count_d[4*i +: 4] = bus.LOAD_VAL[4*i +: 4];
                end
            end
        end else if (bus.EN) begin
            // carry_s doubles as borrow when counting down; it survives
            // the last digit only when every digit rolled over.
            carry_s = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                step_dig_s = count_q[4*i +: 4];
                if (!carry_s) begin
                    count_d[4*i +: 4] = step_dig_s;
                end else if (bus.UP) begin
                    if (step_dig_s >= 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = step_dig_s + 4'd1;
                        carry_s           = 1'b0;
                    end
                end else begin
                    if (step_dig_s == 4'd0) begin
                        count_d[4*i +: 4] = 4'd9;
                    end else begin
                        count_d[4*i +: 4] = step_dig_s - 4'd1;
                        carry_s           = 1'b0;
                    end
                end
            end
            wrap_d = carry_s;
        end else begin
            count_d = count_q;
        end
    end

    // State registers; RST clears them without waiting for CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q    <= {(4*DIGITS){1'b0}};
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Segment decode, top-down leading-zero blanking, then polarity.
    always_comb begin
        led_s        = {(7*DIGITS){1'b0}};
        upper_zero_s = 1'b1;
        disp_dig_s   = 4'd0;
        seg_s        = 7'b0000000;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            disp_dig_s   = count_q[4*i +: 4];
            upper_zero_s = upper_zero_s && (disp_dig_s == 4'd0);
            if (bus.BLANK_ctl && upper_zero_s && (i > 32'sd0)) begin
                seg_s = 7'b0000000;
            end else begin
                seg_s = seg_decode(disp_dig_s);
            end
            if (bus.LED_type_ctl) begin
                led_s[7*i +: 7] = ~seg_s;
            end else begin
                led_s[7*i +: 7] = seg_s;
            end
        end
    end

    assign bus.COUNT    = count_q;
    assign bus.WRAP     = wrap_q;
    assign bus.LOAD_ERR = load_err_q;
    assign bus.LED      = led_s;

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
module tb_bcd_updown_counter_7seg;

    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] count;
        logic        wrap;
        logic        load_err;
        logic [27:0] led;
    } exp_t;

    logic CLK;
    logic RST;
    int   tests;
    int   fails;
    exp_t sb[$];

    bcd_updown_counter_7seg_if #(.DIGITS(DIGITS)) bus ();

    bcd_updown_counter_7seg #(.DIGITS(DIGITS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab[0] = 7'b1111110; tab[1] = 7'b0110000; tab[2] = 7'b1101101;
        tab[3] = 7'b1111001; tab[4] = 7'b0110011; tab[5] = 7'b1011011;
        tab[6] = 7'b1011111; tab[7] = 7'b1110000; tab[8] = 7'b1111111;
        tab[9] = 7'b1111011;
        if (d > 4'd9) return 7'b0000000;
        return tab[d];
    endfunction

    function automatic logic [27:0] ref_led(input logic [15:0] c,
                                            input logic blank,
                                            input logic inv);
        logic [27:0] r;
        logic        lead;
        logic [6:0]  s;
        r    = 28'd0;
        lead = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            lead = lead && (c[4*k +: 4] == 4'd0);
            s    = (blank && lead && k != 0) ? 7'b0000000 : ref_seg(c[4*k +: 4]);
            r[7*k +: 7] = inv ? ~s : s;
        end
        return r;
    endfunction

    // Queue the expected state, using the display controls currently driven.
    task automatic push_exp(input logic [15:0] c, input logic w, input logic e);
        exp_t x;
        x.count    = c;
        x.wrap     = w;
        x.load_err = e;
        x.led      = ref_led(c, bus.BLANK_ctl, bus.LED_type_ctl);
        sb.push_back(x);
    endtask

    task automatic check_now(input string tag);
        exp_t x;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s: observed empty scoreboard, expected an entry", tag);
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            tests++;
            assert (bus.COUNT === x.count) else begin
                fails++;
                $error("FAIL %s.count: observed %h expected %h", tag, bus.COUNT, x.count);
            end
            tests++;
            assert (bus.WRAP === x.wrap) else begin
                fails++;
                $error("FAIL %s.wrap: observed %b expected %b", tag, bus.WRAP, x.wrap);
            end
            tests++;
            assert (bus.LOAD_ERR === x.load_err) else begin
                fails++;
                $error("FAIL %s.load_err: observed %b expected %b", tag, bus.LOAD_ERR, x.load_err);
            end
            tests++;
            assert (bus.LED === x.led) else begin
                fails++;
                $error("FAIL %s.led: observed %b expected %b", tag, bus.LED, x.led);
            end
        end
    endtask

    task automatic clk_check(input string tag);
        @(posedge CLK);
        #1;
        check_now(tag);
    endtask

    task automatic check_led(input string tag, input logic [27:0] exp_led);
        tests++;
        assert (bus.LED === exp_led) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, bus.LED, exp_led);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST = 1'b1;
        bus.EN = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b0; bus.LOAD_VAL = 16'h0000;
        bus.LED_type_ctl = 1'b0; bus.BLANK_ctl = 1'b0;
        #12;
        push_exp(16'h0000, 1'b0, 1'b0);
        check_now("reset");
        check_led("reset_led", {4{7'b1111110}});
        @(negedge CLK);
        RST = 1'b0;
        push_exp(16'h0000, 1'b0, 1'b0);
        clk_check("hold_idle");

        // Up-count carry and full wrap
        bus.LOAD = 1'b1; bus.LOAD_VAL = 16'h0009;
        push_exp(16'h0009, 1'b0, 1'b0); clk_check("load_0009");
        bus.LOAD = 1'b0; bus.EN = 1'b1; bus.UP = 1'b1;
        push_exp(16'h0010, 1'b0, 1'b0); clk_check("inc_carry");
        bus.EN = 1'b0; bus.LOAD = 1'b1; bus.LOAD_VAL = 16'h9999;
        push_exp(16'h9999, 1'b0, 1'b0); clk_check("load_9999");
        bus.LOAD = 1'b0; bus.EN = 1'b1;
        push_exp(16'h0000, 1'b1, 1'b0); clk_check("inc_wrap");
        bus.EN = 1'b0;
        push_exp(16'h0000, 1'b0, 1'b0); clk_check("wrap_one_cycle");

        // Down-count borrow and wrap
        bus.LOAD = 1'b1; bus.LOAD_VAL = 16'h0000;
        push_exp(16'h0000, 1'b0, 1'b0); clk_check("load_0000");
        bus.LOAD = 1'b0; bus.EN = 1'b1; bus.UP = 1'b0;
        push_exp(16'h9999, 1'b1, 1'b0); clk_check("dec_wrap");
        push_exp(16'h9998, 1'b0, 1'b0); clk_check("dec_1");
        push_exp(16'h9997, 1'b0, 1'b0); clk_check("dec_2");

        // Load beats enable; non-BCD digit scrubbed to 0
        bus.LOAD = 1'b1; bus.EN = 1'b1; bus.LOAD_VAL = 16'h12A4;
        push_exp(16'h1204, 1'b0, 1'b1); clk_check("load_err");
        bus.LOAD = 1'b0; bus.EN = 1'b0;
        push_exp(16'h1204, 1'b0, 1'b0); clk_check("load_err_end");

        // Blanking and polarity
        bus.LOAD = 1'b1; bus.LOAD_VAL = 16'h0042; bus.BLANK_ctl = 1'b1;
        push_exp(16'h0042, 1'b0, 1'b0); clk_check("load_0042_blank");
        check_led("blank_pattern", {7'b0000000, 7'b0000000, 7'b0110011, 7'b1101101});
        bus.LOAD = 1'b0;
        bus.LED_type_ctl = 1'b1;
        #1;
        check_led("blank_inverted", {7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010});

        // Direction sampled per edge
        bus.EN = 1'b1; bus.UP = 1'b1;
        push_exp(16'h0043, 1'b0, 1'b0); clk_check("up_step");
        bus.UP = 1'b0;
        push_exp(16'h0042, 1'b0, 1'b0); clk_check("down_step");
        push_exp(16'h0041, 1'b0, 1'b0); clk_check("down_step2");

        // Async reset mid-count
        bus.EN = 1'b0; bus.LOAD = 1'b1; bus.LOAD_VAL = 16'h0000;
        bus.BLANK_ctl = 1'b0; bus.LED_type_ctl = 1'b0;
        push_exp(16'h0000, 1'b0, 1'b0); clk_check("load_zero");
        bus.LOAD = 1'b0; bus.EN = 1'b1; bus.UP = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            push_exp(16'(n), 1'b0, 1'b0); clk_check("count_up");
        end
        #2;
        RST = 1'b1;
        #1;
        push_exp(16'h0000, 1'b0, 1'b0); check_now("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            push_exp(16'(n), 1'b0, 1'b0); clk_check("after_rst");
        end
        bus.EN = 1'b0;

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
